// File: rtl/check_scoreboard.sv
// Multi-channel expected/actual checker: round-robin intake, one compare stage,
// saturating pass/fail/drop counters and a FIFO of failure records.

module chk_lane #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] expected,
    input  logic [WIDTH-1:0] actual,
    input  logic [WIDTH-1:0] mask,
    output logic             fail
);
    assign fail = |((expected ^ actual) & mask);
endmodule

module check_scoreboard #(
    parameter int WIDTH     = 32,
    parameter int CHANNELS  = 2,
    parameter int TAG_W     = 16,
    parameter int LOG_DEPTH = 16,
    parameter int CNT_W     = 32,
    localparam int CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clear,
    input  logic [CHANNELS-1:0]       chk_valid,
    output logic [CHANNELS-1:0]       chk_ready,
    input  logic [CHANNELS*WIDTH-1:0] chk_expected,
    input  logic [CHANNELS*WIDTH-1:0] chk_actual,
    input  logic [CHANNELS*WIDTH-1:0] chk_mask,
    input  logic [CHANNELS*TAG_W-1:0] chk_tag,
    output logic [CNT_W-1:0]          pass_count,
    output logic [CNT_W-1:0]          fail_count,
    output logic [CNT_W-1:0]          dropped_count,
    output logic                      log_overflow,
    output logic                      all_pass,
    output logic                      log_valid,
    input  logic                      log_ready,
    output logic [CW-1:0]             log_channel,
    output logic [TAG_W-1:0]          log_tag,
    output logic [WIDTH-1:0]          log_expected,
    output logic [WIDTH-1:0]          log_actual
);
    localparam int AW = $clog2(LOG_DEPTH);

    typedef struct packed {
        logic [CW-1:0]    ch;
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] exp;
        logic [WIDTH-1:0] act;
    } rec_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [CHANNELS-1:0] lane_fail;

    chk_lane #(.WIDTH(WIDTH)) u_lane [CHANNELS-1:0] (
        .expected (chk_expected),
        .actual   (chk_actual),
        .mask     (chk_mask),
        .fail     (lane_fail)
    );

    // Round-robin arbiter: first requester at or after ptr, wrapping
    logic [CW-1:0]       ptr;
    logic [CW-1:0]       gnt_idx;
    logic [CHANNELS-1:0] gnt;
    logic                found;
    logic                accept;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (!found && chk_valid[(int'(ptr) + k) % CHANNELS]) begin
                found   = 1'b1;
                gnt_idx = CW'((int'(ptr) + k) % CHANNELS);
                gnt[(int'(ptr) + k) % CHANNELS] = 1'b1;
            end
        end
        if (!rst_n || clear)
            gnt = '0;
    end

    assign chk_ready = gnt;
    assign accept    = |gnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            ptr <= '0;
        else if (accept)
            ptr <= CW'((int'(gnt_idx) + 1) % CHANNELS);
    end

    // Compare stage
    logic s1_vld;
    logic s1_fail;
    rec_t s1_rec;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            s1_vld <= 1'b0;
        end else begin
            s1_vld <= accept;
            if (accept) begin
                s1_fail <= lane_fail[gnt_idx];
                s1_rec  <= '{ch:  gnt_idx,
                             tag: chk_tag[gnt_idx*TAG_W +: TAG_W],
                             exp: chk_expected[gnt_idx*WIDTH +: WIDTH],
                             act: chk_actual[gnt_idx*WIDTH +: WIDTH]};
            end
        end
    end

    // Failure FIFO; a push into a full FIFO is allowed when the head pops
    rec_t          mem [LOG_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, pop, push_req, push, drop;

    assign log_valid = (count != '0);
    assign full      = (count == (AW+1)'(LOG_DEPTH));
    assign pop       = log_valid & log_ready;
    assign push_req  = s1_vld & s1_fail;
    assign push      = push_req & (!full | pop);
    assign drop      = push_req & full & !pop;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s1_rec;
    end

    assign log_channel  = mem[rd_ptr].ch;
    assign log_tag      = mem[rd_ptr].tag;
    assign log_expected = mem[rd_ptr].exp;
    assign log_actual   = mem[rd_ptr].act;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            pass_count    <= '0;
            fail_count    <= '0;
            dropped_count <= '0;
            log_overflow  <= 1'b0;
        end else begin
            if (s1_vld) begin
                if (s1_fail) fail_count <= sat_inc(fail_count);
                else         pass_count <= sat_inc(pass_count);
            end
            if (drop) begin
                dropped_count <= sat_inc(dropped_count);
                log_overflow  <= 1'b1;
            end
        end
    end

    assign all_pass = (fail_count == '0) && (pass_count != '0);

endmodule

// File: tb/tb_check_scoreboard.sv
// Directed bench for check_scoreboard: default 2-channel instance plus a tiny
// instance with 2-bit counters to exercise saturation.

module tb_check_scoreboard;
    logic        clk = 1'b0;
    logic        rst_n, clear, log_ready;
    logic [1:0]  chk_valid, chk_ready;
    logic [63:0] chk_expected, chk_actual, chk_mask;
    logic [31:0] chk_tag;
    logic [31:0] pass_count, fail_count, dropped_count;
    logic        log_overflow, all_pass, log_valid;
    logic [0:0]  log_channel;
    logic [15:0] log_tag;
    logic [31:0] log_expected, log_actual;

    logic        s_clear, s_valid, s_ready, s_log_ready;
    logic [7:0]  s_exp, s_act, s_mask;
    logic [3:0]  s_tag;
    logic [1:0]  s_pass, s_fail, s_dropped;
    logic        s_overflow, s_all_pass, s_log_valid;
    logic [0:0]  s_log_channel;
    logic [3:0]  s_log_tag;
    logic [7:0]  s_log_exp, s_log_act;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    check_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .chk_valid(chk_valid), .chk_ready(chk_ready),
        .chk_expected(chk_expected), .chk_actual(chk_actual),
        .chk_mask(chk_mask), .chk_tag(chk_tag),
        .pass_count(pass_count), .fail_count(fail_count),
        .dropped_count(dropped_count), .log_overflow(log_overflow),
        .all_pass(all_pass), .log_valid(log_valid), .log_ready(log_ready),
        .log_channel(log_channel), .log_tag(log_tag),
        .log_expected(log_expected), .log_actual(log_actual)
    );

    check_scoreboard #(.WIDTH(8), .CHANNELS(1), .TAG_W(4), .LOG_DEPTH(2), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .clear(s_clear),
        .chk_valid(s_valid), .chk_ready(s_ready),
        .chk_expected(s_exp), .chk_actual(s_act),
        .chk_mask(s_mask), .chk_tag(s_tag),
        .pass_count(s_pass), .fail_count(s_fail),
        .dropped_count(s_dropped), .log_overflow(s_overflow),
        .all_pass(s_all_pass), .log_valid(s_log_valid), .log_ready(s_log_ready),
        .log_channel(s_log_channel), .log_tag(s_log_tag),
        .log_expected(s_log_exp), .log_actual(s_log_act)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_ch(input int ch, input logic [31:0] e, input logic [31:0] a,
                          input logic [31:0] m, input logic [15:0] t);
        chk_expected[ch*32 +: 32] = e;
        chk_actual[ch*32 +: 32]   = a;
        chk_mask[ch*32 +: 32]     = m;
        chk_tag[ch*16 +: 16]      = t;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; log_ready = 1'b0; chk_valid = '0;
        chk_expected = '0; chk_actual = '0; chk_mask = '0; chk_tag = '0;
        s_clear = 1'b0; s_valid = 1'b0; s_log_ready = 1'b0;
        s_exp = '0; s_act = '0; s_mask = '0; s_tag = '0;

        // Reset: no grants, counters and log cleared
        chk_valid = 2'b11;
        #1 check("rst_ready", chk_ready, 2'b00);
        chk_valid = 2'b00;
        tick(); tick();
        check("rst_pass", pass_count, 0);
        check("rst_fail", fail_count, 0);
        check("rst_drop", dropped_count, 0);
        check("rst_ovf", log_overflow, 0);
        check("rst_logv", log_valid, 0);
        check("rst_allpass", all_pass, 0);
        rst_n = 1'b1;
        tick();

        // One pass then one fail on ch0
        set_ch(0, 5, 5, 32'hFFFF_FFFF, 1);
        chk_valid = 2'b01;
        #1 check("t1_ready", chk_ready, 2'b01);
        tick();
        set_ch(0, 5, 6, 32'hFFFF_FFFF, 2);
        tick();
        check("t1_pass_early", pass_count, 1);
        check("t1_allpass_early", all_pass, 1);
        chk_valid = 2'b00;
        tick();
        check("t1_pass", pass_count, 1);
        check("t1_fail", fail_count, 1);
        check("t1_allpass", all_pass, 0);
        check("t1_logv", log_valid, 1);
        check("t1_logch", log_channel, 0);
        check("t1_logtag", log_tag, 2);
        check("t1_logexp", log_expected, 5);
        check("t1_logact", log_actual, 6);
        log_ready = 1'b1; tick(); log_ready = 1'b0;
        check("t1_logv_pop", log_valid, 0);
        clear = 1'b1; tick(); clear = 1'b0;
        check("t1_clr_pass", pass_count, 0);
        check("t1_clr_fail", fail_count, 0);

        // Both channels requesting: grants alternate starting at ch0
        set_ch(0, 7, 7, 32'hFFFF_FFFF, 10);
        set_ch(1, 9, 9, 32'hFFFF_FFFF, 11);
        chk_valid = 2'b11;
        for (int i = 0; i < 6; i++) begin
            #1 check("t2_gnt", chk_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
        end
        chk_valid = 2'b00;
        check("t2_pass_lag", pass_count, 5);
        tick();
        check("t2_pass", pass_count, 6);
        check("t2_fail", fail_count, 0);
        clear = 1'b1; tick(); clear = 1'b0;

        // Masking on ch1: low-half mask passes, full mask fails, zero mask passes
        chk_valid = 2'b10;
        set_ch(1, 32'h1234_ABCD, 32'hFFFF_ABCD, 32'h0000_FFFF, 20);
        #1 check("t3_ready", chk_ready, 2'b10);
        tick();
        set_ch(1, 32'h1234_ABCD, 32'hFFFF_ABCD, 32'hFFFF_FFFF, 21);
        tick();
        set_ch(1, 32'h0, 32'hFFFF_FFFF, 32'h0, 22);
        tick();
        chk_valid = 2'b00;
        tick();
        check("t3_pass", pass_count, 2);
        check("t3_fail", fail_count, 1);
        check("t3_logch", log_channel, 1);
        check("t3_logtag", log_tag, 21);
        check("t3_logexp", log_expected, 32'h1234_ABCD);
        check("t3_logact", log_actual, 32'hFFFF_ABCD);
        log_ready = 1'b1; tick(); log_ready = 1'b0;
        check("t3_logv_pop", log_valid, 0);
        clear = 1'b1; tick(); clear = 1'b0;

        // 19 back-to-back failures into a 16-entry log with no consumer
        chk_valid = 2'b01;
        for (int i = 0; i < 19; i++) begin
            set_ch(0, i, i ^ 32'h8000_0000, 32'hFFFF_FFFF, 16'(i));
            tick();
        end
        chk_valid = 2'b00;
        tick();
        check("t4_fail", fail_count, 19);
        check("t4_pass", pass_count, 0);
        check("t4_drop", dropped_count, 3);
        check("t4_ovf", log_overflow, 1);
        check("t4_logtag", log_tag, 0);

        // Full log: failing push coincides with a pop
        set_ch(0, 32'hAA, 32'hBB, 32'hFFFF_FFFF, 100);
        chk_valid = 2'b01;
        tick();
        chk_valid = 2'b00;
        log_ready = 1'b1;
        tick();
        log_ready = 1'b0;
        check("t5_fail", fail_count, 20);
        check("t5_drop", dropped_count, 3);
        check("t5_head", log_tag, 1);

        // Drain: tags 1..15 then 100, then empty
        log_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("t5_drain_v", log_valid, 1);
            check("t5_drain_tag", log_tag, (k < 15) ? 64'(k + 1) : 64'd100);
            check("t5_drain_exp", log_expected, (k < 15) ? 64'(k + 1) : 64'hAA);
            tick();
        end
        log_ready = 1'b0;
        check("t5_empty", log_valid, 0);

        // Clear the cycle after an accept discards the in-flight check
        set_ch(0, 1, 2, 32'hFFFF_FFFF, 50);
        chk_valid = 2'b01;
        tick();
        clear = 1'b1;
        #1 check("t6_ready_clr", chk_ready, 2'b00);
        tick();
        clear = 1'b0;
        chk_valid = 2'b00;
        check("t6_fail", fail_count, 0);
        check("t6_drop", dropped_count, 0);
        check("t6_ovf", log_overflow, 0);
        check("t6_logv", log_valid, 0);
        tick();
        check("t6_fail_after", fail_count, 0);
        check("t6_pass_after", pass_count, 0);
        check("t6_logv_after", log_valid, 0);

        // Reset mid-stream: in-flight failure lost, pointer back to 0
        set_ch(0, 3, 4, 32'hFFFF_FFFF, 60);
        set_ch(1, 3, 4, 32'hFFFF_FFFF, 61);
        chk_valid = 2'b11;
        tick();
        check("t7_ready_ptr1", chk_ready, 2'b10);
        rst_n = 1'b0;
        #1 check("t7_ready_rst", chk_ready, 2'b00);
        tick();
        check("t7_fail", fail_count, 0);
        check("t7_pass", pass_count, 0);
        check("t7_logv", log_valid, 0);
        check("t7_ovf", log_overflow, 0);
        rst_n = 1'b1;
        #1 check("t7_ready_ptr0", chk_ready, 2'b01);
        chk_valid = 2'b00;
        tick();

        // Saturation with 2-bit counters
        s_valid = 1'b1; s_exp = 8'h03; s_act = 8'h03; s_mask = 8'hFF; s_tag = 4'd1;
        repeat (5) tick();
        s_valid = 1'b0;
        tick();
        check("sat_pass", s_pass, 3);
        check("sat_allpass", s_all_pass, 1);
        s_act = 8'h04; s_valid = 1'b1;
        repeat (6) tick();
        s_valid = 1'b0;
        tick();
        check("sat_fail", s_fail, 3);
        check("sat_drop", s_dropped, 3);
        check("sat_ovf", s_overflow, 1);
        check("sat_pass_hold", s_pass, 3);
        check("sat_allpass_lo", s_all_pass, 0);
        check("sat_logtag", s_log_tag, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
